// File: rtl/config_chain_loader_if.sv
// Word-delivery handshake between the configuration host and the chain loader.
//   cfg_data   host -> loader   configuration word, bit 0 is shifted first
//   cfg_valid  host -> loader   cfg_data is valid
//   cfg_ready  loader -> host   loader takes the word at this prog_clk edge
// master: the host side. slave: the loader side.
interface config_chain_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/config_chain_loader.sv
// Programming-side driver for the configuration flip-flop chain.
// It takes WORD_W-bit words from the host and shifts them LSB-first into the
// chain through ccff_head. shift_en is high for every chain shift. An
// optional second pass sends the same bitstream again and compares ccff_tail
// with ccff_head.
// Ports:
//   prog_clk   programming clock, all state changes on its rising edge
//   pReset_n   asynchronous active-low reset
//   start      single-cycle pulse that begins a load (honoured in IDLE/DONE)
//   verify     sampled with start: 1 = load pass followed by verify pass
//   cfg        word handshake (slave side): cfg_data, cfg_valid, cfg_ready
//   ccff_head  serial bit into the chain
//   shift_en   the chain advances at this edge
//   ccff_tail  serial bit out of the last chain flip-flop
//   busy       operation in progress (WAIT_WORD or SHIFT)
//   done       operation finished, held until the next start
//   error      sticky verify mismatch, cleared by start
//   bit_cnt    bits shifted in the current pass
module config_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 prog_clk,
    input  logic                 pReset_n,
    input  logic                 start,
    input  logic                 verify,
    config_chain_loader_if.slave cfg,
    output logic                 ccff_head,
    output logic                 shift_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_W-1:0]     bit_cnt
);
    localparam int WB_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN);
    localparam logic [WB_W-1:0]  WORD_END = WB_W'(WORD_W);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, DONE} state_t;

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WB_W-1:0]   word_bits;
    logic              verify_q;
    logic              pass;
    logic              cfg_ready_q;

    logic              accept;
    logic [CNT_W-1:0]  bit_cnt_nx;
    logic [WB_W-1:0]   word_bits_nx;
    logic              chain_full;
    logic              word_end;

    assign cfg.cfg_ready = cfg_ready_q;
    assign accept        = (state == WAIT_WORD) && cfg_ready_q && cfg.cfg_valid;

    // Counts after the shift that happens at the current edge. A word ends
    // after WORD_W bits, or earlier when the chain fills. In that case the
    // unsent MSBs of the final partial word are dropped.
    assign bit_cnt_nx   = bit_cnt + 1'b1;
    assign word_bits_nx = word_bits + 1'b1;
    assign chain_full   = (bit_cnt_nx == LAST_BIT);
    assign word_end     = (word_bits_nx == WORD_END) || chain_full;

    // Bit 0 goes to ccff_head when the word is accepted. shreg keeps the
    // bits still to be sent, so ccff_head can stay a registered output.
    always_ff @(posedge prog_clk) begin
        if (accept) begin
            shreg <= cfg.cfg_data >> 1;
        end else if (state == SHIFT) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state       <= IDLE;
            cfg_ready_q <= 1'b0;
            ccff_head   <= 1'b0;
            shift_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            bit_cnt     <= '0;
            word_bits   <= '0;
            verify_q    <= 1'b0;
            pass        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= WAIT_WORD;
                        cfg_ready_q <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        bit_cnt     <= '0;
                        verify_q    <= verify;
                        pass        <= 1'b0;
                    end
                end
                WAIT_WORD: begin
                    if (accept) begin
                        state       <= SHIFT;
                        cfg_ready_q <= 1'b0;
                        shift_en    <= 1'b1;
                        ccff_head   <= cfg.cfg_data[0];
                        word_bits   <= '0;
                    end
                end
                SHIFT: begin
                    bit_cnt   <= bit_cnt_nx;
                    word_bits <= word_bits_nx;
                    // In the verify pass the chain should return the bit it
                    // got CHAIN_LEN shifts earlier, which is the bit now on
                    // ccff_head.
                    if (pass && (ccff_tail != ccff_head)) begin
                        error <= 1'b1;
                    end
                    if (!word_end) begin
                        ccff_head <= shreg[0];
                    end else begin
                        shift_en  <= 1'b0;
                        ccff_head <= 1'b0;
                        if (!chain_full) begin
                            state       <= WAIT_WORD;
                            cfg_ready_q <= 1'b1;
                        end else if (verify_q && !pass) begin
                            pass        <= 1'b1;
                            bit_cnt     <= '0;
                            state       <= WAIT_WORD;
                            cfg_ready_q <= 1'b1;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader. There are two instances: a 64-bit chain
// with a behavioural flip-flop chain on its tail, and a 20-bit chain. Each
// test lists the expected head bitstream as bits, and one negedge process
// checks every shift against that list.
module tb_config_chain_loader;
    localparam int CL_A = 64;
    localparam int CL_B = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, verify_a, start_b, verify_b;
    logic       head_a, sen_a, tail_a, busy_a, done_a, err_a;
    logic       head_b, sen_b, tail_b, busy_b, done_b, err_b;
    logic [6:0] cnt_a;
    logic [4:0] cnt_b;

    config_chain_loader_if #(.WORD_W(8)) if_a ();
    config_chain_loader_if #(.WORD_W(8)) if_b ();

    config_chain_loader #(.WORD_W(8), .CHAIN_LEN(CL_A)) dut_a (
        .prog_clk(clk), .pReset_n(rst_n), .start(start_a), .verify(verify_a),
        .cfg(if_a), .ccff_head(head_a), .shift_en(sen_a), .ccff_tail(tail_a),
        .busy(busy_a), .done(done_a), .error(err_a), .bit_cnt(cnt_a)
    );

    config_chain_loader #(.WORD_W(8), .CHAIN_LEN(CL_B)) dut_b (
        .prog_clk(clk), .pReset_n(rst_n), .start(start_b), .verify(verify_b),
        .cfg(if_b), .ccff_head(head_b), .shift_en(sen_b), .ccff_tail(tail_b),
        .busy(busy_b), .done(done_b), .error(err_b), .bit_cnt(cnt_b)
    );

    // Behavioural configuration chain behind dut_a. Changing flip_req inverts
    // flip-flop 17 at the next edge.
    logic [CL_A-1:0] chain = '0;
    int flip_req = 0;
    int flip_ack = 0;
    always @(posedge clk) begin
        logic [CL_A-1:0] t;
        t = chain;
        if (sen_a) t = {t[CL_A-2:0], head_a};
        if (flip_req != flip_ack) begin
            t[17] = ~t[17];
            flip_ack = flip_req;
        end
        chain <= t;
    end
    assign tail_a = chain[CL_A-1];
    assign tail_b = 1'b0;

    // Expected head bitstream for each instance, over all passes.
    bit exp_a [0:255];
    bit exp_b [0:63];
    int len_a = 0, fill_a = 0, epoch_a = 0;
    int len_b = 0, fill_b = 0, epoch_b = 0;

    // Compare process.
    int ptr_a = 0, ptr_b = 0, seen_a = 0, seen_b = 0;
    bit merr_a = 1'b0;
    logic [127:0] log_a = '0;
    logic [19:0]  log_b = '0;
    int chk_m = 0, err_m = 0;

    always @(negedge clk) begin
        if (seen_a != epoch_a) begin
            seen_a = epoch_a; ptr_a = 0; merr_a = 1'b0; log_a = '0;
        end
        if (seen_b != epoch_b) begin
            seen_b = epoch_b; ptr_b = 0; log_b = '0;
        end
        if (rst_n) begin
            chk_m++;
            if (sen_a && if_a.cfg_ready) begin
                err_m++;
                $display("FAIL ready_vs_shift_a: cfg_ready=%0b shift_en=%0b, required not both 1", if_a.cfg_ready, sen_a);
            end
            if (sen_a) begin
                chk_m++;
                if (ptr_a >= len_a) begin
                    err_m++;
                    $display("FAIL overrun_a: shift %0d seen, only %0d bits expected", ptr_a, len_a);
                end else begin
                    if (head_a !== exp_a[ptr_a]) begin
                        err_m++;
                        $display("FAIL head_a[%0d]: got %b, required %b", ptr_a, head_a, exp_a[ptr_a]);
                    end
                    chk_m++;
                    if (cnt_a !== 7'(ptr_a % CL_A)) begin
                        err_m++;
                        $display("FAIL bit_cnt_a[%0d]: got %0d, required %0d", ptr_a, cnt_a, ptr_a % CL_A);
                    end
                    chk_m++;
                    if (busy_a !== 1'b1) begin
                        err_m++;
                        $display("FAIL busy_a_in_shift: got %b, required 1", busy_a);
                    end
                    if (ptr_a >= CL_A && tail_a !== exp_a[ptr_a]) merr_a = 1'b1;
                    if (ptr_a < 128) log_a[ptr_a] = head_a;
                    ptr_a++;
                end
            end
            chk_m++;
            if (sen_b && if_b.cfg_ready) begin
                err_m++;
                $display("FAIL ready_vs_shift_b: cfg_ready=%0b shift_en=%0b, required not both 1", if_b.cfg_ready, sen_b);
            end
            if (sen_b) begin
                chk_m++;
                if (ptr_b >= len_b) begin
                    err_m++;
                    $display("FAIL overrun_b: shift %0d seen, only %0d bits expected", ptr_b, len_b);
                end else begin
                    if (head_b !== exp_b[ptr_b]) begin
                        err_m++;
                        $display("FAIL head_b[%0d]: got %b, required %b", ptr_b, head_b, exp_b[ptr_b]);
                    end
                    chk_m++;
                    if (cnt_b !== 5'(ptr_b % CL_B)) begin
                        err_m++;
                        $display("FAIL bit_cnt_b[%0d]: got %0d, required %0d", ptr_b, cnt_b, ptr_b % CL_B);
                    end
                    if (ptr_b < 20) log_b[ptr_b] = head_b;
                    ptr_b++;
                end
            end
        end
    end

    // Directed checks.
    int chk_d = 0, err_d = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        chk_d++;
        if (act !== req) begin
            err_d++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_a(input logic [7:0] w);
        for (int i = 0; i < 8; i++)
            if (fill_a < CL_A) begin exp_a[len_a] = w[i]; len_a++; fill_a++; end
    endtask

    task automatic push_b(input logic [7:0] w);
        for (int i = 0; i < 8; i++)
            if (fill_b < CL_B) begin exp_b[len_b] = w[i]; len_b++; fill_b++; end
    endtask

    task automatic start_pulse_a(input logic v);
        start_a = 1'b1; verify_a = v;
        tick();
        start_a = 1'b0;
    endtask

    task automatic send_a(input logic [7:0] w, input int gap);
        for (int g = 0; g < gap; g++) tick();
        if_a.cfg_data = w; if_a.cfg_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (if_a.cfg_ready) begin
                tick();
                if_a.cfg_valid = 1'b0;
                return;
            end
            tick();
        end
        if_a.cfg_valid = 1'b0;
        chk_d++; err_d++;
        $display("FAIL handshake_timeout_a: word %0h not accepted, required accept within 300 cycles", w);
    endtask

    task automatic send_b(input logic [7:0] w, input int gap);
        for (int g = 0; g < gap; g++) tick();
        if_b.cfg_data = w; if_b.cfg_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if (if_b.cfg_ready) begin
                tick();
                if_b.cfg_valid = 1'b0;
                return;
            end
            tick();
        end
        if_b.cfg_valid = 1'b0;
        chk_d++; err_d++;
        $display("FAIL handshake_timeout_b: word %0h not accepted, required accept within 300 cycles", w);
    endtask

    task automatic wait_done_a(input int lim);
        for (int n = 0; n < lim; n++) begin
            if (done_a === 1'b1) return;
            tick();
        end
        chk_d++; err_d++;
        $display("FAIL done_timeout_a: done=%b after %0d cycles, required 1", done_a, lim);
    endtask

    task automatic wait_done_b(input int lim);
        for (int n = 0; n < lim; n++) begin
            if (done_b === 1'b1) return;
            tick();
        end
        chk_d++; err_d++;
        $display("FAIL done_timeout_b: done=%b after %0d cycles, required 1", done_b, lim);
    endtask

    task automatic verify_run_a(input bit corrupt);
        len_a = 0; fill_a = 0;
        for (int w = 1; w <= 8; w++) push_a(8'(w));
        fill_a = 0;
        for (int w = 1; w <= 8; w++) push_a(8'(w));
        epoch_a++;
        tick();
        start_pulse_a(1'b1);
        for (int w = 1; w <= 8; w++) send_a(8'(w), 0);
        for (int w = 1; w <= 8; w++) begin
            send_a(8'(w), 0);
            if (corrupt && w == 1) flip_req++;
        end
        wait_done_a(600);
    endtask

    initial begin
        logic [7:0] ws [0:7];
        rst_n = 1'b0;
        start_a = 1'b0; verify_a = 1'b0; start_b = 1'b0; verify_b = 1'b0;
        if_a.cfg_data = '0; if_a.cfg_valid = 1'b0;
        if_b.cfg_data = '0; if_b.cfg_valid = 1'b0;
        repeat (3) tick();

        // Reset state.
        chk("rst_busy_a", busy_a, 0);       chk("rst_done_a", done_a, 0);
        chk("rst_error_a", err_a, 0);       chk("rst_shift_en_a", sen_a, 0);
        chk("rst_head_a", head_a, 0);       chk("rst_ready_a", if_a.cfg_ready, 0);
        chk("rst_bit_cnt_a", cnt_a, 0);     chk("rst_busy_b", busy_b, 0);
        chk("rst_ready_b", if_b.cfg_ready, 0); chk("rst_bit_cnt_b", cnt_b, 0);
        rst_n = 1'b1;
        tick();

        // Plain load of words 0x01..0x08 into the 64-bit chain.
        len_a = 0; fill_a = 0;
        for (int w = 1; w <= 8; w++) push_a(8'(w));
        epoch_a++;
        tick();
        start_pulse_a(1'b0);
        chk("start_busy_a", busy_a, 1);
        for (int w = 1; w <= 8; w++) send_a(8'(w), 0);
        wait_done_a(300);
        chk("load_done", done_a, 1);        chk("load_error", err_a, 0);
        chk("load_busy", busy_a, 0);        chk("load_bit_cnt", cnt_a, 64);
        chk("load_shifts", ptr_a, 64);
        chk("load_head_stream", log_a[63:0], 64'h0807060504030201);

        // Load and verify pass over an intact chain.
        verify_run_a(1'b0);
        chk("verify_done", done_a, 1);      chk("verify_error", err_a, 0);
        chk("verify_shifts", ptr_a, 128);   chk("verify_model_err", merr_a, 0);
        chk("verify_bit_cnt", cnt_a, 64);

        // Load and verify with flip-flop 17 corrupted early in the verify pass.
        verify_run_a(1'b1);
        chk("corrupt_done", done_a, 1);     chk("corrupt_error", err_a, 1);
        chk("corrupt_model_err", merr_a, 1); chk("corrupt_shifts", ptr_a, 128);
        repeat (5) tick();
        chk("corrupt_error_held", err_a, 1); chk("corrupt_done_held", done_a, 1);

        // The next start clears error. A reset during its first shift stops
        // everything at once.
        len_a = 0; fill_a = 0; push_a(8'hA5); epoch_a++;
        tick();
        start_pulse_a(1'b0);
        chk("restart_error_cleared", err_a, 0);
        chk("restart_done_cleared", done_a, 0);
        chk("restart_busy", busy_a, 1);
        send_a(8'hA5, 0);
        chk("pre_reset_shift_en", sen_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy_a, 0);   chk("async_rst_shift_en", sen_a, 0);
        chk("async_rst_ready", if_a.cfg_ready, 0); chk("async_rst_head", head_a, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy_a, 0);    chk("post_rst_bit_cnt", cnt_a, 0);
        chk("post_rst_done", done_a, 0);    chk("post_rst_ready", if_a.cfg_ready, 0);

        // Gapped words, valid held during SHIFT, and a start pulse mid-load.
        len_a = 0; fill_a = 0;
        for (int i = 0; i < 8; i++) begin
            ws[i] = 8'($urandom_range(0, 255));
            push_a(ws[i]);
        end
        epoch_a++;
        tick();
        start_pulse_a(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_a(ws[i], $urandom_range(0, 3));
            if (i == 3) begin
                start_pulse_a(1'b1);
                chk("midload_start_busy", busy_a, 1);
            end
        end
        wait_done_a(400);
        chk("stress_done", done_a, 1);      chk("stress_shifts", ptr_a, 64);
        chk("stress_error", err_a, 0);      chk("stress_bit_cnt", cnt_a, 64);
        if_a.cfg_valid = 1'b1;
        repeat (3) tick();
        chk("done_valid_ready", if_a.cfg_ready, 0);
        chk("done_valid_shift_en", sen_a, 0);
        chk("done_valid_done", done_a, 1);
        if_a.cfg_valid = 1'b0;

        // 20-bit chain with words 0xFF, 0xFF, 0xAB. start and cfg_valid
        // arrive together, and only start acts.
        len_b = 0; fill_b = 0;
        push_b(8'hFF); push_b(8'hFF); push_b(8'hAB);
        epoch_b++;
        tick();
        start_b = 1'b1; verify_b = 1'b0;
        if_b.cfg_data = 8'hFF; if_b.cfg_valid = 1'b1;
        tick();
        start_b = 1'b0;
        chk("start_valid_shift_en_b", sen_b, 0);
        chk("start_valid_ready_b", if_b.cfg_ready, 1);
        chk("start_valid_busy_b", busy_b, 1);
        send_b(8'hFF, 0);
        send_b(8'hFF, 0);
        send_b(8'hAB, 0);
        wait_done_b(200);
        chk("short_done", done_b, 1);       chk("short_error", err_b, 0);
        chk("short_shifts", ptr_b, 20);     chk("short_bit_cnt", cnt_b, 20);
        chk("short_stream", log_b, 20'hBFFFF);
        chk("short_last_nibble", log_b[19:16], 4'b1011);

        $display("Simulation finished: %0d checks, %0d errors", chk_d + chk_m, err_d + err_m);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, required to end earlier");
        $fatal(1);
    end
endmodule
